writeback_unit: RTL
===================

// Module: writeback_unit
// PURPOSE
//  Final pipeline stage; sits directly downstream of the memacc->writeback pipeline register.
//  Selects the load result or the ALU result and drives the regfile write port through a 1-cycle register.
//  Also keeps a per-register pending-write scoreboard, fed by decode at issue and drained here at retire.
//  From the scoreboard it generates the combinational RAW stall back to decode, and it counts retired instructions.
// PARAMETERS
//  NREGS     32  architectural registers (x0 hardwired zero)
//  CNT_W     2   width of per-register in-flight counter; MAX = 2**CNT_W-1
//  RETIRE_W  32  width of retired-instruction counter
// PORTS
//  clk              in   1   clock
//  rst              in   1   reset, synchronous, active-high
//  issue_v          in   1   decode issues an instruction writing issue_rd this cycle
//  issue_rd         in   5   destination register of issuing instruction
//  chk_rs1_v        in   1   decode's rs1 operand is used
//  chk_rs1          in   5   decode's rs1 index
//  chk_rs2_v        in   1   decode's rs2 operand is used
//  chk_rs2          in   5   decode's rs2 index
//  stall            out  1   combinational; decode must hold its instruction and not issue
//  wb_in_v          in   1   instruction present in memacc->writeback register
//  wb_in_rd         in   5   its destination register
//  wb_in_load       in   1   1 = take wb_in_load_data, 0 = take wb_in_alu
//  wb_in_load_data  in   32  memory read data
//  wb_in_alu        in   32  exec result
//  rf_we            out  1   regfile write enable (registered)
//  rf_waddr         out  5   regfile write address (registered)
//  rf_wdata         out  32  regfile write data (registered)
//  retired          out  RETIRE_W  count of retired instructions
//  sb_err           out  1   sticky: retire seen for a register with zero pending count
// BEHAVIOUR
//  Reset (sync, rst=1 at posedge):
//  - All outputs return to reset values: rf_we=0, rf_waddr=0, rf_wdata=0, retired=0, sb_err=0, cnt[*]=0.
//  - Reset overrides any simultaneous issue or retire.
//  - Reset mid-operation discards all in-flight scoreboard state.
//  Write path, latency 1:
//  - At posedge with wb_in_v=1:
//    - rf_we <= (wb_in_rd!=0).
//    - rf_waddr <= wb_in_rd.
//    - rf_wdata <= wb_in_load ? wb_in_load_data : wb_in_alu.
//  - At posedge with wb_in_v=0: rf_we <= 0; rf_waddr and rf_wdata hold their values.
//  Retire:
//  - Each posedge with wb_in_v=1 increments retired by 1, including rd=0.
//  - retired wraps modulo 2**RETIRE_W.
//  Scoreboard, cnt[r] of CNT_W bits per register; cnt[0] is always 0:
//  - inc = issue_v & !stall & issue_rd!=0.
//  - dec = wb_in_v & wb_in_rd!=0.
//  - inc only: cnt[issue_rd]++.
//  - dec only: cnt[wb_in_rd]--.
//  - inc and dec on the same register: that count is unchanged.
//  - inc and dec on different registers: both updates apply.
//  - dec with cnt[wb_in_rd]==0: count stays 0 and sb_err <= 1 (sticky until reset).
//  Stall, combinational:
//  - Source rsN is busy if chk_rsN_v & rsN!=0 & (cnt[rsN]!=0 | (rf_we & rf_waddr==rsN)).
//    The second term covers a write still one edge away from landing in the regfile.
//  - stall = rs1 busy | rs2 busy | (issue_v & issue_rd!=0 & cnt[issue_rd]==MAX).
//  - The last term is counter-full backpressure: the counter never overflows.
//  - While stall=1, issue_v is ignored for the scoreboard.
// TESTING
//  - Reset: rst=1 for 1 cycle with prior state -> next cycle rf_we=0, retired=0, sb_err=0, stall=0 for any rs.
//  - ALU writeback: wb_in_v=1, rd=5, load=0, alu=0x1234 -> one cycle later rf_we=1, waddr=5, wdata=0x1234, retired=1.
//  - Load select and x0:
//    - wb_in_v=1, rd=7, load=1, load_data=0xDEADBEEF -> wdata=0xDEADBEEF.
//    - Same with rd=0 -> rf_we=0, retired still increments.
//  - RAW stall:
//    - Issue rd=3.
//    - Next cycle chk_rs1_v=1, rs1=3 -> stall=1.
//    - Stall persists through the retire of rd=3 and the cycle rf_we=1, waddr=3.
//    - Stall drops the cycle after.
//  - Saturation: issue rd=9 three times with no retire (cnt=3), then issue_v=1, rd=9 -> stall=1 and cnt stays 3.
//  - Simultaneous events:
//    - Same-cycle issue rd=4 and retire rd=4 with cnt[4]=1 -> cnt[4] stays 1.
//    - Retire rd=6 with cnt[6]=0 -> sb_err=1, held until rst.

Source files
------------

// File: rtl/writeback_unit.sv
// Final pipeline stage: selects the load or ALU result and drives a registered regfile write port.
// It also keeps the per-register pending-write scoreboard behind decode's RAW stall and counts retirements.
module writeback_unit #(
    parameter int NREGS    = 32,
    parameter int CNT_W    = 2,
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_v,
    input  logic [4:0]          issue_rd,
    input  logic                chk_rs1_v,
    input  logic [4:0]          chk_rs1,
    input  logic                chk_rs2_v,
    input  logic [4:0]          chk_rs2,
    output logic                stall,
    input  logic                wb_in_v,
    input  logic [4:0]          wb_in_rd,
    input  logic                wb_in_load,
    input  logic [31:0]         wb_in_load_data,
    input  logic [31:0]         wb_in_alu,
    output logic                rf_we,
    output logic [4:0]          rf_waddr,
    output logic [31:0]         rf_wdata,
    output logic [RETIRE_W-1:0] retired,
    output logic                sb_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NREGS-1:0][CNT_W-1:0] cnt_vec;
    logic                        rs1_busy;
    logic                        rs2_busy;
    logic                        issue_full;
    logic                        inc;
    logic                        dec;

    logic                        rf_we_reg;
    logic [4:0]                  rf_waddr_reg;
    logic [31:0]                 rf_wdata_reg;
    logic [RETIRE_W-1:0]         retired_reg;
    logic                        sb_err_reg;

    // A source is also busy while its write sits in the output register, one edge before the regfile sees it.
    always_comb begin
        rs1_busy   = chk_rs1_v && (chk_rs1 != 5'd0) &&
                     ((cnt_vec[chk_rs1] != '0) || (rf_we_reg && (rf_waddr_reg == chk_rs1)));
        rs2_busy   = chk_rs2_v && (chk_rs2 != 5'd0) &&
                     ((cnt_vec[chk_rs2] != '0) || (rf_we_reg && (rf_waddr_reg == chk_rs2)));
        issue_full = issue_v && (issue_rd != 5'd0) && (cnt_vec[issue_rd] == CNT_MAX);
        stall      = rs1_busy || rs2_busy || issue_full;
        inc        = issue_v && !stall && (issue_rd != 5'd0);
        dec        = wb_in_v && (wb_in_rd != 5'd0);
    end

    assign cnt_vec[0] = '0;

    genvar gi;
    generate
        for (gi = 1; gi < NREGS; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] cnt_next;
            logic             inc_hit;
            logic             dec_hit;

            // Issue and retire on the same register cancel; a retire at zero is clamped (and flagged below).
            always_comb begin
                inc_hit  = inc && (issue_rd == 5'(gi));
                dec_hit  = dec && (wb_in_rd == 5'(gi));
                cnt_next = cnt_reg;
                if (inc_hit && !dec_hit) begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end else if (dec_hit && !inc_hit && (cnt_reg != '0)) begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_next;
                end
            end

            assign cnt_vec[gi] = cnt_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we_reg    <= 1'b0;
            rf_waddr_reg <= 5'd0;
            rf_wdata_reg <= 32'd0;
            retired_reg  <= '0;
            sb_err_reg   <= 1'b0;
        end else begin
            if (wb_in_v) begin
                rf_we_reg    <= (wb_in_rd != 5'd0);
                rf_waddr_reg <= wb_in_rd;
                rf_wdata_reg <= wb_in_load ? wb_in_load_data : wb_in_alu;
                retired_reg  <= retired_reg + RETIRE_W'(1);
            end else begin
                rf_we_reg <= 1'b0;
            end
            if (dec && (cnt_vec[wb_in_rd] == '0)) begin
                sb_err_reg <= 1'b1;
            end
        end
    end

    assign rf_we    = rf_we_reg;
    assign rf_waddr = rf_waddr_reg;
    assign rf_wdata = rf_wdata_reg;
    assign retired  = retired_reg;
    assign sb_err   = sb_err_reg;

endmodule
